// File: rtl/keypad_scan_debounce.sv
// 4x3 keypad scanner: column strobing, full-matrix frame debounce and single-key decode.
// Emits one key_valid per debounced press; simultaneous presses raise multi_err and are locked out.
module keypad_scan_debounce #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_in,
    output logic [2:0] col_drive,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       key_held,
    output logic       multi_err
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
    localparam logic [3:0]    DEB       = 4'(DEBOUNCE_SCANS);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_HELD    = 2'd1;
    localparam logic [1:0] ST_LOCKOUT = 2'd2;

    logic [3:0]    row_meta;
    logic [3:0]    row_sync;
    logic [SW-1:0] slot;
    logic [11:0]   frame;
    logic [11:0]   prev_frame;
    logic [11:0]   frame_next;
    logic [3:0]    stable_cnt;
    logic [3:0]    stable_cnt_next;
    logic [1:0]    state;
    logic          sample;
    logic          frame_end;
    logic          stable;
    logic [3:0]    key_count;
    logic [3:0]    decoded;

    // Frame bit index is row*3+col, so each column owns bits {9+c, 6+c, 3+c, c}.
    always_comb begin
        sample     = (slot == SLOT_LAST);
        frame_end  = sample && col_drive[2];
        frame_next = frame;
        if (col_drive[0]) {frame_next[9],  frame_next[6], frame_next[3], frame_next[0]} = row_sync;
        if (col_drive[1]) {frame_next[10], frame_next[7], frame_next[4], frame_next[1]} = row_sync;
        if (col_drive[2]) {frame_next[11], frame_next[8], frame_next[5], frame_next[2]} = row_sync;

        if (frame_next == prev_frame)
            stable_cnt_next = (stable_cnt >= DEB) ? DEB : stable_cnt + 4'd1;
        else
            stable_cnt_next = 4'd1;
        stable    = (stable_cnt_next == DEB);
        key_count = 4'($countones(frame_next));

        case (frame_next)
            12'h001: decoded = 4'h1;
            12'h002: decoded = 4'h2;
            12'h004: decoded = 4'h3;
            12'h008: decoded = 4'h4;
            12'h010: decoded = 4'h5;
            12'h020: decoded = 4'h6;
            12'h040: decoded = 4'h7;
            12'h080: decoded = 4'h8;
            12'h100: decoded = 4'h9;
            12'h200: decoded = 4'hA;
            12'h400: decoded = 4'h0;
            12'h800: decoded = 4'hB;
            default: decoded = 4'hF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row_meta   <= '0;
            row_sync   <= '0;
            slot       <= '0;
            col_drive  <= 3'b001;
            frame      <= '0;
            prev_frame <= '0;
            stable_cnt <= '0;
            state      <= ST_IDLE;
            key_valid  <= 1'b0;
            key_code   <= 4'hF;
            key_held   <= 1'b0;
            multi_err  <= 1'b0;
        end else begin
            row_meta  <= row_in;
            row_sync  <= row_meta;
            key_valid <= 1'b0;
            multi_err <= 1'b0;

            if (sample) begin
                slot      <= '0;
                col_drive <= {col_drive[1:0], col_drive[2]};
                frame     <= frame_next;
            end else begin
                slot <= slot + SW'(1);
            end

            if (frame_end) begin
                prev_frame <= frame_next;
                stable_cnt <= stable_cnt_next;
                case (state)
                    ST_IDLE: begin
                        if (stable && key_count == 4'd1) begin
                            key_valid <= 1'b1;
                            key_code  <= decoded;
                            key_held  <= 1'b1;
                            state     <= ST_HELD;
                        end else if (stable && key_count > 4'd1) begin
                            multi_err <= 1'b1;
                            state     <= ST_LOCKOUT;
                        end
                    end
                    ST_HELD: begin
                        if (stable && key_count == 4'd0) begin
                            key_held <= 1'b0;
                            state    <= ST_IDLE;
                        end
                    end
                    ST_LOCKOUT: begin
                        if (stable && key_count == 4'd0)
                            state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Bench for keypad_scan_debounce: a physical keypad model drives rows from col_drive, and a
// frame-level reference model predicts strobes, key code and held flag.
module tb_keypad_scan_debounce;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 3;

    localparam logic [3:0] KEY_CODE [12] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6,
                                             4'h7, 4'h8, 4'h9, 4'hA, 4'h0, 4'hB};

    localparam logic [11:0] K1 = 12'h001, K3 = 12'h004, K5 = 12'h010, K8 = 12'h080;
    localparam logic [11:0] K9 = 12'h100, KSTAR = 12'h200, K0 = 12'h400, KHASH = 12'h800;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  row_in;
    logic [2:0]  col_drive;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_held;
    logic        multi_err;
    logic [11:0] pressed;

    int errors = 0;
    int checks = 0;

    // Reference model: frames seen since reset, plus the pressed/locked situation.
    logic [11:0] hist[$];
    bit          m_held;
    bit          m_locked;
    logic [3:0]  m_code;

    keypad_scan_debounce #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .row_in    (row_in),
        .col_drive (col_drive),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_held  (key_held),
        .multi_err (multi_err)
    );

    always #5 clk = ~clk;

    // A closed switch connects its row to the driven column.
    assign row_in = {|(pressed[11:9] & col_drive), |(pressed[8:6] & col_drive),
                     |(pressed[5:3] & col_drive),  |(pressed[2:0] & col_drive)};

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        m_held   = 1'b0;
        m_locked = 1'b0;
        m_code   = 4'hF;
    endtask

    task automatic model_frame(input logic [11:0] f, output bit ev_valid, output bit ev_multi);
        bit stable;
        int n;
        ev_valid = 1'b0;
        ev_multi = 1'b0;
        hist.push_back(f);
        if (hist.size() > DEB) void'(hist.pop_front());
        stable = (hist.size() == DEB);
        foreach (hist[i]) if (hist[i] !== f) stable = 1'b0;
        n = $countones(f);
        if (!m_held && !m_locked) begin
            if (stable && n == 1) begin
                ev_valid = 1'b1;
                m_held   = 1'b1;
                m_code   = KEY_CODE[$clog2(f)];
            end else if (stable && n > 1) begin
                ev_multi = 1'b1;
                m_locked = 1'b1;
            end
        end else if (stable && n == 0) begin
            m_held   = 1'b0;
            m_locked = 1'b0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        model_reset();
        check("rst_col_drive", 12'(col_drive), 12'h001);
        check("rst_key_valid", 12'(key_valid), 12'h0);
        check("rst_key_code",  12'(key_code),  12'hF);
        check("rst_key_held",  12'(key_held),  12'h0);
        check("rst_multi_err", 12'(multi_err), 12'h0);
        reset = 1'b0;
    endtask

    // One 12-clock frame with a fixed key set; outputs move only after the col3 sample edge.
    task automatic run_frame(input logic [11:0] keys);
        bit         ev_v;
        bit         ev_m;
        bit         last;
        logic       o_held;
        logic [3:0] o_code;
        logic [2:0] exp_col;
        pressed = keys;
        o_held  = m_held;
        o_code  = m_code;
        model_frame(keys, ev_v, ev_m);
        for (int j = 1; j <= 3 * SCAN_DIV; j++) begin
            @(posedge clk); #1;
            last    = (j == 3 * SCAN_DIV);
            exp_col = (j < SCAN_DIV) ? 3'b001 : (j < 2 * SCAN_DIV) ? 3'b010 :
                      (j < 3 * SCAN_DIV) ? 3'b100 : 3'b001;
            check("col_drive", 12'(col_drive), 12'(exp_col));
            check("key_valid", 12'(key_valid), 12'(last && ev_v));
            check("multi_err", 12'(multi_err), 12'(last && ev_m));
            check("key_held",  12'(key_held),  12'(last ? m_held : o_held));
            check("key_code",  12'(key_code),  12'(last ? m_code : o_code));
        end
    endtask

    task automatic run_frames(input logic [11:0] keys, input int n);
        for (int i = 0; i < n; i++) run_frame(keys);
    endtask

    initial begin
        pressed = '0;
        reset   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        do_reset();

        run_frames('0, 3);

        run_frames(K5, 5);
        run_frames('0, 3);

        run_frames(KSTAR, 4);
        run_frames('0, 4);
        run_frames(KHASH, 4);
        run_frames('0, 4);

        for (int i = 0; i < 6; i++) run_frame((i % 2 == 0) ? K8 : 12'h000);
        run_frames(K8, 4);
        run_frames(K8 | K5, 3);
        run_frames('0, 4);

        run_frames(K1 | K9, 4);
        run_frames('0, 3);
        run_frames(K0, 4);
        run_frames('0, 4);

        run_frames(K3, 4);
        pressed = K3;
        do_reset();
        run_frames(K3, 4);
        run_frames('0, 4);

        for (int s = 0; s < 40; s++) begin
            int          kind;
            int          a;
            int          b;
            logic [11:0] keys;
            kind = int'($urandom_range(0, 3));
            a    = int'($urandom_range(0, 11));
            b    = (a + 1 + int'($urandom_range(0, 10))) % 12;
            keys = '0;
            if (kind >= 1) keys[a] = 1'b1;
            if (kind == 3) keys[b] = 1'b1;
            run_frames(keys, int'($urandom_range(1, 5)));
        end
        run_frames('0, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
